// File: rtl/wb_spi_host.sv
// -----------------------------------------------------------------------------
// wb_spi_host
//   Wishbone slave that drives a byte-oriented SPI master (mode 0, MSB first).
//   The CPU writes a byte to DATA. The byte is shifted out on MOSI, and the byte
//   clocked in on MISO during the same transfer is captured into RX. Chip select
//   is a plain software-controlled bit, so the driver builds multi-byte frames.
//
// Register map (s_wb_adr_i[3:2]):
//   0 CTRL    [0] cs_en (RW), o_spi_cs_n = ~cs_en
//   1 STATUS  [0] busy, [1] rx_valid, [2] tx_full, [3] overrun (write 1 to clear)
//   2 DATA    write: load TX hold byte; read: {24'b0, rx_byte}, clears rx_valid
//   3 CLKDIV  [15:0] (RW); SCK half-period = CLKDIV+1 clock cycles
//
// Ports:
//   i_clk, i_rst      system clock, synchronous active-high reset
//   s_wb_*            Wishbone slave; single-cycle ack, err on DATA write when full
//   o_spi_clk         SCK, idles low
//   o_spi_mosi        MOSI
//   i_spi_miso        MISO
//   o_spi_cs_n        chip select, active low
//   o_irq             level interrupt, equal to STATUS.rx_valid
// -----------------------------------------------------------------------------
module wb_spi_host #(
    parameter logic [15:0] CLKDIV_RESET = 16'd3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] s_wb_adr_i,
    input  logic [31:0] s_wb_dat_i,
    output logic [31:0] s_wb_dat_o,
    input  logic        s_wb_we_i,
    input  logic [3:0]  s_wb_sel_i,
    input  logic        s_wb_stb_i,
    input  logic        s_wb_cyc_i,
    output logic        s_wb_ack_o,
    output logic        s_wb_err_o,
    output logic        o_spi_clk,
    output logic        o_spi_mosi,
    input  logic        i_spi_miso,
    output logic        o_spi_cs_n,
    output logic        o_irq
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DATA   = 2'd2;
    localparam logic [1:0] REG_CLKDIV = 2'd3;

    state_t      state;
    logic [15:0] clkdiv;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [7:0]  hold;
    logic [7:0]  rx_byte;
    logic        cs_en;
    logic        busy;
    logic        rx_valid;
    logic        tx_full;
    logic        overrun;
    logic        wb_held;

    logic        access;
    logic        load;
    logic [1:0]  reg_sel;
    logic        data_wr;
    logic        data_err;
    logic [31:0] rd_data;

    // Byte selects and the undecoded address/data bits play no part in the design.
    logic unused_bits;
    assign unused_bits = ^{s_wb_sel_i, s_wb_adr_i[31:4], s_wb_adr_i[1:0], s_wb_dat_i[31:16]};

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        // wb_held blocks a second access while the master keeps stb up after its response.
        access   = s_wb_stb_i & s_wb_cyc_i & ~wb_held;
        load     = (state == IDLE) & tx_full;
        reg_sel  = s_wb_adr_i[3:2];
        data_wr  = access & s_wb_we_i & (reg_sel == REG_DATA);
        // A write that coincides with the IDLE load finds the hold register being emptied.
        data_err = data_wr & tx_full & ~load;
        rd_data  = '0;
        case (reg_sel)
            REG_CTRL:   rd_data = {31'b0, cs_en};
            REG_STATUS: rd_data = {28'b0, overrun, tx_full, rx_valid, busy};
            REG_DATA:   rd_data = {24'b0, rx_byte};
            REG_CLKDIV: rd_data = {16'b0, clkdiv};
            default:    rd_data = '0;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register sees
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            clkdiv     <= CLKDIV_RESET;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            hold       <= '0;
            rx_byte    <= '0;
            cs_en      <= 1'b0;
            busy       <= 1'b0;
            rx_valid   <= 1'b0;
            tx_full    <= 1'b0;
            overrun    <= 1'b0;
            wb_held    <= 1'b0;
            s_wb_ack_o <= 1'b0;
            s_wb_err_o <= 1'b0;
            s_wb_dat_o <= '0;
            o_spi_clk  <= 1'b0;
            o_spi_mosi <= 1'b0;
        end else begin
            // ---------------- Wishbone side ----------------
            s_wb_ack_o <= access & ~data_err;
            s_wb_err_o <= data_err;
            s_wb_dat_o <= (access && !s_wb_we_i) ? rd_data : '0;

            if (access) begin
                wb_held <= 1'b1;
            end else if (!(s_wb_stb_i && s_wb_cyc_i)) begin
                wb_held <= 1'b0;
            end

            if (access && s_wb_we_i && !data_err) begin
                case (reg_sel)
                    REG_CTRL:   cs_en <= s_wb_dat_i[0];
                    REG_STATUS: if (s_wb_dat_i[3]) overrun <= 1'b0;
                    REG_DATA: begin
                        hold    <= s_wb_dat_i[7:0];
                        tx_full <= 1'b1;
                    end
                    REG_CLKDIV: clkdiv <= s_wb_dat_i[15:0];
                    default: ;
                endcase
            end

            if (access && !s_wb_we_i && (reg_sel == REG_DATA)) begin
                rx_valid <= 1'b0;
            end

            // ---------------- SPI shifter ----------------
            // Placed after the bus logic so a completing byte wins over a
            // same-cycle DATA read or overrun clear.
            case (state)
                IDLE: begin
                    if (tx_full) begin
                        shreg      <= hold;
                        o_spi_mosi <= hold[7];
                        // A same-cycle DATA write refills the hold register.
                        tx_full    <= data_wr;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        bit_idx    <= '0;
                        state      <= LOW;
                    end
                end
                LOW: begin
                    // >= keeps a mid-byte CLKDIV decrease from wrapping the counter.
                    if (cnt >= clkdiv) begin
                        o_spi_clk <= 1'b1;
                        shreg     <= {shreg[6:0], i_spi_miso};
                        cnt       <= '0;
                        state     <= HIGH;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                HIGH: begin
                    if (cnt >= clkdiv) begin
                        o_spi_clk <= 1'b0;
                        cnt       <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= DONE;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            // After the shift the next transmit bit sits in the MSB.
                            o_spi_mosi <= shreg[7];
                            state      <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE: begin
                    rx_byte  <= shreg;
                    rx_valid <= 1'b1;
                    if (rx_valid) overrun <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_spi_cs_n = ~cs_en;
    assign o_irq      = rx_valid;

endmodule
